// File: rtl/jesd_rx_char_replace.sv
// JESD204B RX per-lane alignment-character monitor: locks multiframe position from /A/,
// restores octets replaced by /F/ and /A/, flags misplaced K characters.
// Optional JESD_RX_CHAR_STATS_EN adds saturating replacement / error counters.
module jesd_rx_char_replace #(
  parameter int OCTETS     = 2,
  parameter int FRAMES     = 32,
  parameter int ERR_THRESH = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] rx_data,
  input  logic       rx_is_k,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       frame_start,
  output logic       mf_start,
  output logic       aligned,
  output logic       align_err
`ifdef JESD_RX_CHAR_STATS_EN
  ,
  output logic [15:0] repl_cnt,
  output logic [15:0] err_cnt_total
`endif
);

  localparam int OW = (OCTETS > 1) ? $clog2(OCTETS) : 1;
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int PW = OW + FW;
  localparam int EW = 3;

  localparam logic [7:0] K_A = 8'h7C;
  localparam logic [7:0] K_F = 8'hFC;

  typedef enum logic {UNALIGNED, ALIGNED} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   octet_cnt_q, octet_cnt_d;
  logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [7:0]      last_octet_q, last_octet_d;
  logic [EW-1:0]   err_cnt_q, err_cnt_d;
  logic [PW-1:0]   err_pos_q, err_pos_d;

  logic          accept;
  logic          is_a, is_f;
  logic          end_pos, mf_end;
  logic [PW-1:0] cur_pos;
  logic [EW-1:0] bump;
  logic [7:0]    dout_d;
  logic          replace, err_pulse, realign, load_anchor;

  assign accept  = en & rx_valid;
  assign is_a    = rx_is_k && (rx_data == K_A);
  assign is_f    = rx_is_k && (rx_data == K_F);
  assign end_pos = (octet_cnt_q == OW'(OCTETS - 1));
  assign mf_end  = end_pos && (frame_cnt_q == FW'(FRAMES - 1));
  assign cur_pos = {frame_cnt_q, octet_cnt_q};
  assign aligned = (state_q == ALIGNED);

  // State register
  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clock) begin
    if (reset) state_q <= UNALIGNED;
    else       state_q <= state_d;
  end

  // Next state: the first accepted /A/ locks; realignment never leaves ALIGNED
  always_comb begin
    state_d = state_q;
    if (accept && state_q == UNALIGNED && is_a) state_d = ALIGNED;
  end

  // Octet classification, restoration and misplaced-/A/ tracking
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    dout_d       = rx_data;
    replace      = 1'b0;
    err_pulse    = 1'b0;
    realign      = 1'b0;
    last_octet_d = last_octet_q;
    err_cnt_d    = err_cnt_q;
    err_pos_d    = err_pos_q;
    bump         = EW'(1);
    if (state_q == ALIGNED) begin
      if ((is_a && mf_end) || (is_f && end_pos && !mf_end)) begin
        dout_d  = last_octet_q;
        replace = 1'b1;
        if (is_a) err_cnt_d = '0;
      end else if (rx_is_k) begin
        err_pulse = 1'b1;
        if (is_a) begin
          if (err_cnt_q != '0 && err_pos_q == cur_pos) bump = err_cnt_q + EW'(1);
          if (bump >= EW'(ERR_THRESH)) begin
            realign   = 1'b1;
            err_cnt_d = '0;
          end else begin
            err_cnt_d = bump;
            err_pos_d = cur_pos;
          end
        end
      end else if (end_pos) begin
        last_octet_d = rx_data;
      end
    end
  end

  // Position counters: an anchoring /A/ is the MF end, so the next octet is (0,0)
  assign load_anchor = (state_q == UNALIGNED && is_a) || realign;

  always_comb begin
    octet_cnt_d = octet_cnt_q + OW'(1);
    frame_cnt_d = frame_cnt_q;
    if (load_anchor) begin
      octet_cnt_d = '0;
      frame_cnt_d = '0;
    end else if (end_pos) begin
      octet_cnt_d = '0;
      frame_cnt_d = (frame_cnt_q == FW'(FRAMES - 1)) ? '0 : frame_cnt_q + FW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      octet_cnt_q  <= '0;
      frame_cnt_q  <= '0;
      last_octet_q <= '0;
      err_cnt_q    <= '0;
      err_pos_q    <= '0;
      dout         <= '0;
      dout_valid   <= 1'b0;
      frame_start  <= 1'b0;
      mf_start     <= 1'b0;
      align_err    <= 1'b0;
    end else begin
      dout_valid  <= accept;
      frame_start <= 1'b0;
      mf_start    <= 1'b0;
      align_err   <= 1'b0;
      if (accept) begin
        octet_cnt_q  <= octet_cnt_d;
        frame_cnt_q  <= frame_cnt_d;
        last_octet_q <= last_octet_d;
        err_cnt_q    <= err_cnt_d;
        err_pos_q    <= err_pos_d;
        dout         <= dout_d;
        frame_start  <= aligned && (octet_cnt_q == '0);
        mf_start     <= aligned && (octet_cnt_q == '0) && (frame_cnt_q == '0);
        align_err    <= err_pulse;
      end
    end
  end

`ifdef JESD_RX_CHAR_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      repl_cnt      <= '0;
      err_cnt_total <= '0;
    end else if (accept) begin
      if (replace && repl_cnt != 16'hFFFF)        repl_cnt      <= repl_cnt + 16'd1;
      if (err_pulse && err_cnt_total != 16'hFFFF) err_cnt_total <= err_cnt_total + 16'd1;
    end
  end
`endif

endmodule
